// File: rtl/adc_stream_packer.sv
// AD4003 readout back end: snapshots all channel words per sample strobe and
// streams them as a header + sign-extended channel frame on a 32-bit AXI4-Stream.

package adc_stream_packer_pkg;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   typedef struct packed {
      logic [7:0]  magic;
      logic [7:0]  n_ch;
      logic [15:0] seq;
   } hdr_t;

endpackage

module adc_stream_packer
   import adc_stream_packer_pkg::*;
#(
   parameter int unsigned ADC_CHANNELS   = 8,
   parameter int unsigned ADC_DATA_WIDTH = 18
) (
   input  logic                                   adc_read_clk,
   input  logic                                   rstn,
   input  logic                                   acq_en,
   input  logic                                   sample_valid,
   input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
   output logic [31:0]                            m_axis_tdata,
   output logic                                   m_axis_tvalid,
   input  logic                                   m_axis_tready,
   output logic                                   m_axis_tlast,
   output logic [31:0]                            sample_cnt,
   output logic                                   overrun
);

   localparam int unsigned BUS_W   = 32;
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned CH_W    = (ADC_CHANNELS > 1) ? $clog2(ADC_CHANNELS) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(ADC_CHANNELS - 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t                    state_q, state_d;
   logic [CH_W-1:0]           ch_q, ch_d, ch_nxt;
   logic [ADC_DATA_WIDTH-1:0] shadow_q [ADC_CHANNELS];
   logic [ADC_DATA_WIDTH-1:0] shadow_d [ADC_CHANNELS];
   logic [BUS_W-1:0]          tdata_q, tdata_d;
   logic                      tvalid_q, tvalid_d;
   logic                      tlast_q, tlast_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      ovr_q, ovr_d;

   logic hs, last_hs, accept, drop;
   hdr_t hdr;

   function automatic logic [BUS_W-1:0] sext(input logic [ADC_DATA_WIDTH-1:0] w);
      return {{(BUS_W - ADC_DATA_WIDTH){w[ADC_DATA_WIDTH-1]}}, w};
   endfunction

   // A new sample may start a frame only when idle or exactly as the last beat leaves
   assign hs      = tvalid_q & m_axis_tready;
   assign last_hs = (state_q == DATA) && (ch_q == CH_LAST) && hs;
   assign accept  = sample_valid & acq_en & ((state_q == IDLE) | last_hs);
   assign drop    = sample_valid & acq_en & ~accept;

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      shadow_d = shadow_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      cnt_d    = cnt_q;
      ovr_d    = ovr_q;
      ch_nxt   = ch_q + CH_W'(1);
      hdr      = '{magic: HDR_MAGIC, n_ch: 8'(ADC_CHANNELS), seq: cnt_q[15:0]};

      unique case (state_q)
         IDLE: state_d = IDLE;
         HDR: begin
            if (hs) begin
               state_d = DATA;
               ch_d    = '0;
               tdata_d = sext(shadow_q[0]);
               tlast_d = (CH_LAST == '0);
            end
         end
         DATA: begin
            if (hs) begin
               if (ch_q == CH_LAST) begin
                  state_d  = IDLE;
                  ch_d     = '0;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
               end else begin
                  ch_d    = ch_nxt;
                  tdata_d = sext(shadow_q[ch_nxt]);
                  tlast_d = (ch_nxt == CH_LAST);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Accept overrides the end-of-frame transition so frames run back to back
      if (accept) begin
         for (int unsigned c = 0; c < ADC_CHANNELS; c++) begin
            shadow_d[c] = adc_data_arr[c*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
         end
         state_d  = HDR;
         ch_d     = '0;
         tdata_d  = hdr;
         tvalid_d = 1'b1;
         tlast_d  = 1'b0;
      end

      if (!acq_en) begin
         cnt_d = '0;
         ovr_d = 1'b0;
      end else begin
         if (accept) cnt_d = cnt_q + CNT_W'(1);
         if (drop)   ovr_d = 1'b1;
      end
   end

   always_ff @(posedge adc_read_clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         ch_q     <= '0;
         shadow_q <= '{default: '0};
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         cnt_q    <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         shadow_q <= shadow_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         cnt_q    <= cnt_d;
         ovr_q    <= ovr_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign sample_cnt    = cnt_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_adc_stream_packer.sv
// Directed + randomized bench for adc_stream_packer against a frame-queue reference model.

module tb_adc_stream_packer;

   localparam int unsigned N = 8;
   localparam int unsigned W = 18;

   logic           clk = 1'b0;
   logic           rstn;
   logic           acq_en;
   logic           sample_valid;
   logic [W*N-1:0] adc_data_arr;
   logic [31:0]    m_axis_tdata;
   logic           m_axis_tvalid;
   logic           m_axis_tready;
   logic           m_axis_tlast;
   logic [31:0]    sample_cnt;
   logic           overrun;

   adc_stream_packer #(.ADC_CHANNELS(N), .ADC_DATA_WIDTH(W)) dut (
      .adc_read_clk (clk),
      .rstn         (rstn),
      .acq_en       (acq_en),
      .sample_valid (sample_valid),
      .adc_data_arr (adc_data_arr),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .sample_cnt   (sample_cnt),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [32:0] exp_q[$];     // {tlast, tdata} of every beat still owed by the DUT
   logic [31:0] got[$];
   int unsigned m_cnt;
   logic        m_ovr;
   logic        prev_stall;
   logic [31:0] prev_data;
   logic        prev_last;
   logic        accepted;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] sx(input logic [W-1:0] w);
      int v;
      v = int'(w);
      if (v >= (1 << (W - 1))) v = v - (1 << W);
      return 32'(v);
   endfunction

   function automatic logic [W*N-1:0] rand_arr();
      logic [W*N-1:0] a;
      for (int c = 0; c < int'(N); c++) a[c*W +: W] = W'($urandom);
      return a;
   endfunction

   task automatic push_frame(input logic [W*N-1:0] arr, input int unsigned seq);
      logic [15:0] s;
      s = seq[15:0];
      exp_q.push_back({1'b0, 8'hA5, 8'(N), s});
      for (int c = 0; c < int'(N); c++)
         exp_q.push_back({(c == int'(N) - 1), sx(arr[c*W +: W])});
   endtask

   // One clock: check outputs at the falling edge, then advance the model for this cycle's inputs
   task automatic cycle();
      int unsigned outstanding;
      @(negedge clk);
      chk("sample_cnt", {1'b0, sample_cnt}, {1'b0, 32'(m_cnt)});
      chk("overrun", 33'(overrun), 33'(m_ovr));
      chk("tvalid", 33'(m_axis_tvalid), 33'(exp_q.size() != 0));
      if (prev_stall) begin
         chk("stable_tdata", {1'b0, m_axis_tdata}, {1'b0, prev_data});
         chk("stable_tlast", 33'(m_axis_tlast), 33'(prev_last));
      end
      outstanding = exp_q.size();
      if (m_axis_tvalid && m_axis_tready) begin
         got.push_back(m_axis_tdata);
         if (exp_q.size() != 0) chk("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      accepted   = 1'b0;
      if (!acq_en) begin
         m_cnt = 0;
         m_ovr = 1'b0;
      end else if (sample_valid) begin
         if (outstanding == 0 || (outstanding == 1 && m_axis_tready)) begin
            push_frame(adc_data_arr, m_cnt);
            m_cnt++;
            accepted = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic strobe(input logic [W*N-1:0] arr);
      sample_valid = 1'b1;
      adc_data_arr = arr;
      cycle();
      sample_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cycle();
      chk("drain", 33'(exp_q.size()), 33'(0));
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_tvalid", 33'(m_axis_tvalid), 33'(0));
      chk("rst_tlast", 33'(m_axis_tlast), 33'(0));
      chk("rst_tdata", {1'b0, m_axis_tdata}, 33'(0));
      chk("rst_cnt", {1'b0, sample_cnt}, 33'(0));
      chk("rst_ovr", 33'(overrun), 33'(0));
      exp_q.delete();
      m_cnt      = 0;
      m_ovr      = 1'b0;
      prev_stall = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W*N-1:0] arr;
      int             frames;
      rstn          = 1'b1;
      acq_en        = 1'b0;
      sample_valid  = 1'b0;
      adc_data_arr  = '0;
      m_axis_tready = 1'b1;
      m_cnt         = 0;
      m_ovr         = 1'b0;
      prev_stall    = 1'b0;
      prev_data     = '0;
      prev_last     = 1'b0;
      accepted      = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // First frame: known corner words on channels 0 and 1
      acq_en = 1'b1;
      arr = rand_arr();
      arr[0 +: W] = 18'h3FFFF;
      arr[W +: W] = 18'h1FFFF;
      got.delete();
      strobe(arr);
      idle(int'(N) + 2);
      chk("first_beats", 33'(got.size()), 33'(N + 1));
      chk("first_hdr", {1'b0, got[0]}, {1'b0, 32'hA508_0000});
      chk("first_ch0", {1'b0, got[1]}, {1'b0, 32'hFFFF_FFFF});
      chk("first_ch1", {1'b0, got[2]}, {1'b0, 32'h0001_FFFF});
      chk("first_cnt", {1'b0, sample_cnt}, 33'(1));

      // 100 frames under random backpressure, count cleared first
      acq_en = 1'b0;
      cycle();
      acq_en = 1'b1;
      frames = 0;
      for (int i = 0; i < 6000 && frames < 100; i++) begin
         sample_valid  = (exp_q.size() == 0) && ($urandom_range(0, 1) == 1);
         adc_data_arr  = rand_arr();
         m_axis_tready = ($urandom_range(0, 3) != 0);
         cycle();
         if (accepted) frames++;
      end
      sample_valid  = 1'b0;
      m_axis_tready = 1'b1;
      drain();
      chk("bp_frames", 33'(frames), 33'(100));
      chk("bp_cnt", {1'b0, sample_cnt}, 33'(100));

      // Strobe 4 cycles after an accept is dropped
      acq_en = 1'b0;
      cycle();
      acq_en = 1'b1;
      strobe(rand_arr());
      idle(3);
      strobe(rand_arr());
      drain();
      chk("drop_cnt", {1'b0, sample_cnt}, 33'(1));
      chk("drop_ovr", 33'(overrun), 33'(1));

      // Strobe coinciding with the tlast handshake chains frames with no gap
      acq_en = 1'b0;
      cycle();
      acq_en = 1'b1;
      got.delete();
      strobe(rand_arr());
      idle(int'(N));
      strobe(rand_arr());
      drain();
      chk("chain_beats", 33'(got.size()), 33'(2 * (N + 1)));
      chk("chain_cnt", {1'b0, sample_cnt}, 33'(2));
      chk("chain_ovr", 33'(overrun), 33'(0));

      // acq_en dropped mid-frame: frame completes, counters clear, strobes ignored
      got.delete();
      strobe(rand_arr());
      idle(2);
      strobe(rand_arr());
      acq_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         sample_valid = ($urandom_range(0, 1) == 1);
         adc_data_arr = rand_arr();
         cycle();
      end
      sample_valid = 1'b0;
      drain();
      chk("acqoff_beats", 33'(got.size()), 33'(N + 1));
      chk("acqoff_cnt", {1'b0, sample_cnt}, 33'(0));
      chk("acqoff_ovr", 33'(overrun), 33'(0));

      // Reset while beat 4 is presented, then a fresh frame starts at count 0
      acq_en = 1'b1;
      got.delete();
      strobe(rand_arr());
      idle(3);
      chk("pre_rst_beats", 33'(got.size()), 33'(3));
      chk("pre_rst_cnt", {1'b0, sample_cnt}, 33'(1));
      do_reset();
      got.delete();
      strobe(rand_arr());
      idle(int'(N) + 2);
      chk("post_rst_beats", 33'(got.size()), 33'(N + 1));
      chk("post_rst_hdr", {1'b0, got[0]}, {1'b0, 32'hA508_0000});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
